fpu_arbiter: RTL and testbench

Shares the single fixed-point unit (add/sub/mul/sqrt, Q-format result, level `ready`) between `NUM_REQ` requesters such as the integer pipeline and the load/store address path. It grants requests round-robin, drives and holds the FPU operands for the whole operation, and captures the result when the FPU signals ready. It returns the result to the granted requester tagged by a one-hot response strobe. It sits between the requester ports and the FPU instance in the execute stage.

---
 rtl/fpu_arb_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/fpu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fpu_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
// -----------------------------------------------------------------------------
// fpu_arb_pkg
// Shared definitions for the FPU arbiter: fixed-point unit opcodes, the
// arbiter FSM state encoding, and the index-width helper used to size the
// requester index and the round-robin pointer.
// -----------------------------------------------------------------------------
package fpu_arb_pkg;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_SQRT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Bits needed to hold an index 0..n-1, never less than one bit.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << w) < n) w++;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant. The search starts at (ptr + 1) mod
// NUM_REQ and the first set request bit wins. The pointer register is owned by
// the instantiating block.
//
// Ports:
//   req    in  NUM_REQ  request vector
//   ptr    in  IDX_W    index granted last time
//   grant  out NUM_REQ  one-hot grant (all zero when no request)
//   index  out IDX_W    binary index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   index
);

   logic [IDX_W-1:0] cand;
   logic             found;

   // NOTE: every variable written in this block gets a value before any
   // conditional logic, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant = '0;
      index = '0;
      cand  = '0;
      found = 1'b0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            index       = cand;
         end
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_arbiter
// Shares one fixed-point unit between NUM_REQ requesters. Requests are granted
// round-robin in IDLE, operands are registered and held on the FPU inputs,
// the result is captured when the FPU raises ready, and it is returned with a
// one-cycle one-hot strobe to the requester that issued it.
//
// Optional feature (macro FPU_ARB_TIMEOUT_EN): a WAIT watchdog that returns an
// error response with result 0 after TIMEOUT WAIT cycles without fpu_ready.
// Without the macro WAIT lasts until fpu_ready and rsp_error stays 0.
//
// Ports:
//   clk, reset                        rising-edge clock, async active-high reset
//   req_valid/req_ready     NUM_REQ   request handshake (ready at most one-hot)
//   req_operand_1/_2  NUM_REQ*WIDTH   packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_operation     NUM_REQ*2       packed opcodes
//   rsp_valid               NUM_REQ   one-hot one-cycle response strobe
//   rsp_result/rsp_error              response data, valid with rsp_valid
//   fpu_operand_1/_2, fpu_operation   held FPU inputs
//   fpu_result, fpu_ready             FPU result and result-valid level
// -----------------------------------------------------------------------------
module fpu_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_operand_1,
   input  logic [NUM_REQ*WIDTH-1:0]   req_operand_2,
   input  logic [NUM_REQ*2-1:0]       req_operation,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [WIDTH-1:0]           rsp_result,
   output logic                       rsp_error,
   output logic [WIDTH-1:0]           fpu_operand_1,
   output logic [WIDTH-1:0]           fpu_operand_2,
   output logic [1:0]                 fpu_operation,
   input  logic [WIDTH-1:0]           fpu_result,
   input  logic                       fpu_ready
);

   localparam int IDX_W = clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("fpu_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
   end

   state_e           state, state_next;
   logic [IDX_W-1:0] ptr, idx;
   logic [WIDTH-1:0] op1_q, op2_q, result_q;
   logic [1:0]       opc_q;
   logic             error_q;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               accept, capture, timeout;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .index (grant_idx)
   );

`ifdef FPU_ARB_TIMEOUT_EN
   localparam int CNT_W = clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] wait_cnt;

   // Cleared during ISSUE so it reads 0 in the first WAIT cycle; it saturates
   // at the last count, which is the WAIT cycle that gives up.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                       wait_cnt <= '0;
      else if (state == ST_ISSUE)                      wait_cnt <= '0;
      else if (state == ST_WAIT && wait_cnt != CNT_LAST) wait_cnt <= wait_cnt + 1'b1;
   end

   assign timeout = (state == ST_WAIT) && !fpu_ready && (wait_cnt == CNT_LAST);
`else
   assign timeout = 1'b0;
`endif

   // fpu_ready is only trusted in WAIT; during ISSUE it still reflects the
   // previous opcode.
   assign capture = (state == ST_WAIT) && fpu_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      req_ready  = '0;
      rsp_valid  = '0;
      rsp_result = '0;
      rsp_error  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            // Gated by reset so req_ready reads 0 while reset is held.
            if (!reset) req_ready = grant;
            if (|req_valid) begin
               accept     = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: state_next = ST_WAIT;
         ST_WAIT: begin
            if (capture || timeout) state_next = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid  = NUM_REQ'(1) << idx;
            rsp_result = result_q;
            rsp_error  = error_q;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Operand/opcode registers drive the FPU directly and change only on
   // accept, so the FPU sees stable inputs from ISSUE through the next IDLE.
   // NOTE: the datapath registers are reset as well, because the FPU inputs
   // and response outputs must read 0/ADD immediately on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op1_q    <= '0;
         op2_q    <= '0;
         opc_q    <= OP_ADD;
         idx      <= '0;
         ptr      <= IDX_W'(NUM_REQ - 1);
         result_q <= '0;
         error_q  <= 1'b0;
      end else begin
         if (accept) begin
            op1_q <= req_operand_1[grant_idx*WIDTH +: WIDTH];
            op2_q <= req_operand_2[grant_idx*WIDTH +: WIDTH];
            opc_q <= req_operation[grant_idx*2 +: 2];
            idx   <= grant_idx;
         end
         if (capture) begin
            result_q <= fpu_result;
            error_q  <= 1'b0;
         end else if (timeout) begin
            result_q <= '0;
            error_q  <= 1'b1;
         end
         if (state == ST_RESP) ptr <= idx;
      end
   end

   assign fpu_operand_1 = op1_q;
   assign fpu_operand_2 = op2_q;
   assign fpu_operation = opc_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpu_arbiter
// Directed bench for fpu_arbiter (NUM_REQ=4, WIDTH=32, TIMEOUT=8) with a
// behavioural Q22.10 fixed-point unit. The model latches its inputs one edge
// after they change; its result and ready level always describe the latched
// (previous) inputs, so ready is stale during the arbiter's ISSUE cycle.
// Per-opcode ready delays are counted in edges after latching; `hang` keeps
// ready low. Watchdog expectations follow FPU_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_fpu_arbiter;
   import fpu_arb_pkg::*;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk, reset;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_operand_1, req_operand_2;
   logic [N*2-1:0] req_operation;
   logic [N-1:0]   rsp_valid;
   logic [W-1:0]   rsp_result;
   logic           rsp_error;
   logic [W-1:0]   fpu_operand_1, fpu_operand_2;
   logic [1:0]     fpu_operation;
   logic [W-1:0]   fpu_result;
   logic           fpu_ready;

   fpu_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_operand_1 (req_operand_1),
      .req_operand_2 (req_operand_2),
      .req_operation (req_operation),
      .rsp_valid     (rsp_valid),
      .rsp_result    (rsp_result),
      .rsp_error     (rsp_error),
      .fpu_operand_1 (fpu_operand_1),
      .fpu_operand_2 (fpu_operand_2),
      .fpu_operation (fpu_operation),
      .fpu_result    (fpu_result),
      .fpu_ready     (fpu_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- FPU model ----------------
   logic [W-1:0] m_op1 = '0, m_op2 = '0;
   logic [1:0]   m_opc = OP_ADD;
   int           age = 0;
   int           delay_add = 0, delay_mul = 0, delay_sqrt = 0;
   bit           hang = 0;

   function automatic logic [W-1:0] fx_sqrt(input logic [W-1:0] a);
      logic [63:0] x, r, t;
      x = {22'd0, a, 10'd0};
      r = '0;
      for (int i = 31; i >= 0; i--) begin
         t = r | (64'd1 << i);
         if (t * t <= x) r = t;
      end
      return r[W-1:0];
   endfunction

   function automatic logic [W-1:0] fx_model(input logic [W-1:0] a, b, input logic [1:0] op);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_MUL:  return p[41:10];
         default: return fx_sqrt(a);
      endcase
   endfunction

   always @(posedge clk) begin
      if ({fpu_operand_1, fpu_operand_2, fpu_operation} != {m_op1, m_op2, m_opc}) begin
         m_op1 <= fpu_operand_1;
         m_op2 <= fpu_operand_2;
         m_opc <= fpu_operation;
         age   <= 0;
      end else if (age < 100000) begin
         age <= age + 1;
      end
   end

   always_comb begin
      int d;
      d = (m_opc == OP_MUL) ? delay_mul : (m_opc == OP_SQRT) ? delay_sqrt : delay_add;
      fpu_result = fx_model(m_op1, m_op2, m_opc);
      fpu_ready  = !hang && (age >= d);
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick;
      tick;
      reset = 1'b0;
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a, b);
      req_operation[i*2 +: 2] = op;
      req_operand_1[i*W +: W] = a;
      req_operand_2[i*W +: W] = b;
   endtask

   // Raise one request, check its grant, let it be accepted, then drop it.
   task automatic issue_req(input string tag, input int i, input logic [1:0] op,
                            input logic [W-1:0] a, b);
      int n;
      n = 0;
      set_req(i, op, a, b);
      req_valid[i] = 1'b1;
      #1;
      while (req_ready == '0 && n < 20) begin
         tick;
         n++;
      end
      check({tag, "_grant"}, 64'(req_ready), 64'(4'b1 << i));
      tick;
      req_valid[i] = 1'b0;
   endtask

   // Called in the ISSUE cycle. Measures edges to the response, checks it,
   // checks the strobe is one cycle, and checks the FPU inputs stayed put.
   task automatic wait_rsp(input string tag, input logic [N-1:0] exp_valid,
                           input logic [W-1:0] exp_res, input logic exp_err,
                           input int exp_lat, input logic [W-1:0] e1, e2,
                           input logic [1:0] eop);
      int lat, unstable;
      lat      = 0;
      unstable = 0;
      while (rsp_valid == '0 && lat < 60) begin
         if ({fpu_operand_1, fpu_operand_2, fpu_operation} != {e1, e2, eop}) unstable++;
         tick;
         lat++;
      end
      check({tag, "_lat"},    64'(lat),        64'(exp_lat));
      check({tag, "_valid"},  64'(rsp_valid),  64'(exp_valid));
      check({tag, "_result"}, 64'(rsp_result), 64'(exp_res));
      check({tag, "_error"},  64'(rsp_error),  64'(exp_err));
      if ({fpu_operand_1, fpu_operand_2, fpu_operation} != {e1, e2, eop}) unstable++;
      tick;
      if ({fpu_operand_1, fpu_operand_2, fpu_operation} != {e1, e2, eop}) unstable++;
      check({tag, "_one"},  64'(rsp_valid), 64'(0));
      check({tag, "_hold"}, 64'(unstable),  64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation bound exceeded");
   end

   initial begin
      int n, g, seen;

      reset         = 1'b1;
      req_valid     = '0;
      req_operand_1 = '0;
      req_operand_2 = '0;
      req_operation = '0;
      tick;
      tick;

      // Reset state
      check("rst_req_ready",  64'(req_ready),     64'(0));
      check("rst_rsp_valid",  64'(rsp_valid),     64'(0));
      check("rst_rsp_result", 64'(rsp_result),    64'(0));
      check("rst_rsp_error",  64'(rsp_error),     64'(0));
      check("rst_fpu_op1",    64'(fpu_operand_1), 64'(0));
      check("rst_fpu_op2",    64'(fpu_operand_2), 64'(0));
      check("rst_fpu_opc",    64'(fpu_operation), 64'(OP_ADD));
      reset = 1'b0;
      tick;

      // Single request: requester 1, 1.5 + 2.0 = 3.5
      issue_req("single", 1, OP_ADD, 32'h600, 32'h800);
      check("single_issue_op1", 64'(fpu_operand_1), 64'h600);
      wait_rsp("single", 4'b0010, 32'hE00, 1'b0, 2, 32'h600, 32'h800, OP_ADD);

      // Contention: all four hold MUL ((i+1) * 2.0); grants 0,1,2,3,0
      do_reset;
      for (int i = 0; i < N; i++) set_req(i, OP_MUL, W'((i + 1) << 10), 32'h800);
      req_valid = 4'hF;
      #1;
      for (int k = 0; k < 5; k++) begin
         g = k % N;
         n = 0;
         while (req_ready == '0 && n < 20) begin
            tick;
            n++;
         end
         check("rr_grant", 64'(req_ready), 64'(4'b1 << g));
         tick;
         check("rr_busy_ready", 64'(req_ready), 64'(0));
         wait_rsp("rr", N'(4'b1 << g), W'((g + 1) << 11), 1'b0, 2,
                  W'((g + 1) << 10), 32'h800, OP_MUL);
      end
      req_valid = '0;
      #1;

      // Slow FPU: 1.5 * 2.0 = 3.0 with ready delayed 10 edges
      delay_mul = 10;
      issue_req("slow", 2, OP_MUL, 32'h600, 32'h800);
`ifdef FPU_ARB_TIMEOUT_EN
      wait_rsp("slow", 4'b0100, 32'h0, 1'b1, 9, 32'h600, 32'h800, OP_MUL);
`else
      wait_rsp("slow", 4'b0100, 32'hC00, 1'b0, 12, 32'h600, 32'h800, OP_MUL);
`endif
      delay_mul = 0;

      // Stale-ready guard: ADD then SQRT(9.0)=3.0 with ready delayed 5 edges
      issue_req("stale_add", 2, OP_ADD, 32'h400, 32'h400);
      wait_rsp("stale_add", 4'b0100, 32'h800, 1'b0, 2, 32'h400, 32'h400, OP_ADD);
      delay_sqrt = 5;
      issue_req("stale_sqrt", 2, OP_SQRT, 32'h2400, 32'h0);
      wait_rsp("stale_sqrt", 4'b0100, 32'hC00, 1'b0, 7, 32'h2400, 32'h0, OP_SQRT);

      // Reset mid-WAIT: drop the in-flight MUL, then requester 0 wins first
      delay_mul = 10;
      issue_req("midrst", 3, OP_MUL, 32'h600, 32'h800);
      repeat (4) tick;
      set_req(0, OP_ADD, 32'h400, 32'h400);
      req_valid = 4'b1001;
      reset     = 1'b1;
      #1;
      check("midrst_req_ready",  64'(req_ready),     64'(0));
      check("midrst_rsp_valid",  64'(rsp_valid),     64'(0));
      check("midrst_rsp_result", 64'(rsp_result),    64'(0));
      check("midrst_rsp_error",  64'(rsp_error),     64'(0));
      check("midrst_fpu_op1",    64'(fpu_operand_1), 64'(0));
      check("midrst_fpu_op2",    64'(fpu_operand_2), 64'(0));
      check("midrst_fpu_opc",    64'(fpu_operation), 64'(OP_ADD));
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         tick;
         if (rsp_valid != '0 || req_ready != '0) seen++;
      end
      check("midrst_quiet", 64'(seen), 64'(0));
      reset = 1'b0;
      #1;
      check("midrst_first_grant", 64'(req_ready), 64'(4'b0001));
      tick;
      req_valid = '0;
      wait_rsp("midrst_add", 4'b0001, 32'h800, 1'b0, 2, 32'h400, 32'h400, OP_ADD);
      delay_mul = 0;

      // Watchdog: FPU never ready
      hang = 1;
      issue_req("wdog", 1, OP_ADD, 32'h100, 32'h200);
`ifdef FPU_ARB_TIMEOUT_EN
      wait_rsp("wdog", 4'b0010, 32'h0, 1'b1, 9, 32'h100, 32'h200, OP_ADD);
      hang = 0;
      issue_req("wdog_after", 1, OP_SUB, 32'h800, 32'h200);
      wait_rsp("wdog_after", 4'b0010, 32'h600, 1'b0, 2, 32'h800, 32'h200, OP_SUB);
`else
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (rsp_valid != '0) seen++;
         if (fpu_operand_1 != 32'h100) seen++;
         tick;
      end
      check("wdog_stays_wait", 64'(seen), 64'(0));
      hang = 0;
      do_reset;
      issue_req("wdog_after", 0, OP_SUB, 32'h800, 32'h200);
      wait_rsp("wdog_after", 4'b0001, 32'h600, 1'b0, 2, 32'h800, 32'h200, OP_SUB);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
